// File: rtl/message_receiver_pkg.sv
// rtl/message_receiver_pkg.sv - shared link constants and receiver state encoding
package message_receiver_pkg;

  // Whole encoded message width, shared with encoder, decoder and transmitter
  localparam int MSG_WIDTH     = 128;
  localparam int BIT_CNT_WIDTH = $clog2(MSG_WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/message_receiver_rx_out_buffer.sv
// rtl/message_receiver_rx_out_buffer.sv - one-entry valid/ready output register with overrun detect
module rx_out_buffer
  import message_receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MSG_WIDTH-1:0] frame_data,
  input  logic                 frame_done,
  input  logic                 msg_ready,
  output logic [MSG_WIDTH-1:0] msg_out,
  output logic                 msg_valid,
  output logic                 overrun,
  output logic                 load_fire,
  output logic                 overrun_fire
);

  logic pop;

  // A completed frame is taken if the slot is empty or being freed this cycle
  always_comb begin
    pop          = msg_valid && msg_ready;
    load_fire    = frame_done && (!msg_valid || msg_ready);
    overrun_fire = frame_done && msg_valid && !msg_ready;
  end

  // Slot register: load wins over pop; msg_out only changes on a load
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_out   <= '0;
      msg_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= overrun_fire;
      if (load_fire) begin
        msg_out   <= frame_data;
        msg_valid <= 1'b1;
      end else if (pop) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/message_receiver.sv
// rtl/message_receiver.sv - serial frame deserialiser with timeout, framing and overrun tracking
module message_receiver
  import message_receiver_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  input  logic                 rx_valid,
  input  logic                 rx_sof,
  output logic [MSG_WIDTH-1:0] msg_out,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] frames_ok,
  output logic [CNT_WIDTH-1:0] frames_dropped
);

  localparam int TW = $clog2(TIMEOUT);

  state_t                   state;
  state_t                   next_state;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic [TW-1:0]            timer;
  logic [MSG_WIDTH-1:0]     shreg;
  logic [MSG_WIDTH-1:0]     frame_data;

  logic start_frame;
  logic shift_bit;
  logic tick;
  logic err_evt;
  logic timeout_evt;
  logic frame_done;
  logic load_fire;
  logic overrun_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state: enter SHIFT on sof, leave on last bit or inter-bit timeout
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start_frame) next_state = ST_SHIFT;
      ST_SHIFT: if (frame_done || timeout_evt) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Control decode: a mid-frame sof is both an error and the start of a new frame
  always_comb begin
    start_frame = 1'b0;
    shift_bit   = 1'b0;
    tick        = 1'b0;
    err_evt     = 1'b0;
    timeout_evt = 1'b0;
    frame_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && rx_sof) start_frame = 1'b1;
      end
      ST_SHIFT: begin
        if (rx_valid && rx_sof) begin
          start_frame = 1'b1;
          err_evt     = 1'b1;
        end else if (rx_valid) begin
          shift_bit  = 1'b1;
          frame_done = (bit_cnt == BIT_CNT_WIDTH'(MSG_WIDTH - 1));
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          err_evt     = 1'b1;
        end else begin
          tick = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The final bit bypasses the shift register so the frame is ready on its strobe
  always_comb begin
    frame_data                = shreg;
    frame_data[MSG_WIDTH-1]   = rx_bit;
  end

  // Shift register, bit counter and inter-bit timer
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      timer   <= '0;
    end else if (start_frame) begin
      shreg[0] <= rx_bit;
      bit_cnt  <= BIT_CNT_WIDTH'(1);
      timer    <= '0;
    end else if (shift_bit) begin
      shreg[bit_cnt] <= rx_bit;
      bit_cnt        <= bit_cnt + BIT_CNT_WIDTH'(1);
      timer          <= '0;
    end else if (tick) begin
      timer <= timer + TW'(1);
    end else if (timeout_evt) begin
      bit_cnt <= '0;
      timer   <= '0;
    end
  end

  // Error pulse and frame statistics; error and overrun are mutually exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_error    <= 1'b0;
      frames_ok      <= '0;
      frames_dropped <= '0;
    end else begin
      frame_error <= err_evt;
      if (load_fire)               frames_ok      <= frames_ok + CNT_WIDTH'(1);
      if (err_evt || overrun_fire) frames_dropped <= frames_dropped + CNT_WIDTH'(1);
    end
  end

  rx_out_buffer u_out_buf (
    .clk          (clk),
    .rst          (rst),
    .frame_data   (frame_data),
    .frame_done   (frame_done),
    .msg_ready    (msg_ready),
    .msg_out      (msg_out),
    .msg_valid    (msg_valid),
    .overrun      (overrun),
    .load_fire    (load_fire),
    .overrun_fire (overrun_fire)
  );

endmodule
